orb_temp_reader: RTL and testbench

ORB_TEMP_READER -- requirements
Module: orb_temp_reader

---
 rtl/orb_temp_reader.sv | 142 ++++++++++++++
 tb/tb_orb_temp_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/orb_temp_reader.sv
// orb_temp_reader: picks the packed temperature word out of an ORB frame
// group, reads it from frame RAM and unpacks it.
module orb_temp_reader #(
  parameter logic [10:0] TEMP_ADDR = 11'd831,
  parameter int          RD_LAT    = 2,
  parameter int          QUAL      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strob,
  input  logic        SW,
  input  logic [10:0] frameAddr,
  input  logic [11:0] rdData,
  output logic        RE,
  output logic [10:0] rdAddr,
  output logic [9:0]  tempOut,
  output logic        tempValid,
  output logic        fmtErr,
  output logic [4:0]  wordCnt
);

  localparam logic [1:0] QMAX = 2'(QUAL - 1);
  localparam logic [2:0] LMAX = 3'(RD_LAT - 2);
  localparam logic [4:0] LAST = 5'd17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUALIFY,
    S_READ,
    S_LAT,
    S_CAPTURE,
    S_WAIT
  } state_t;

  state_t     state;
  logic [1:0] strob_sync;
  logic [1:0] sw_sync;
  logic       sw_prev;
  logic [1:0] qual_cnt;
  logic [2:0] lat_cnt;
  logic       strob_s;
  logic       sw_edge;
  logic       qual_hit;

  assign strob_s = strob_sync[1];
  assign sw_edge = sw_sync[1] ^ sw_prev;

  // Strobe has stayed high long enough to count as a word strobe
  always_comb begin
    qual_hit = 1'b0;
    if (state == S_QUALIFY && strob_s && qual_cnt == QMAX)
      qual_hit = 1'b1;
  end

  // Two-flop synchronizers for the asynchronous strobe and group switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strob_sync <= '0;
      sw_sync    <= '0;
      sw_prev    <= 1'b0;
    end else begin
      strob_sync <= {strob_sync[0], strob};
      sw_sync    <= {sw_sync[0], SW};
      sw_prev    <= sw_sync[1];
    end
  end

  // Word counter: group switch restarts it, qualified strobes advance it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordCnt <= '0;
    end else if (sw_edge) begin
      wordCnt <= '0;
    end else if (qual_hit) begin
      wordCnt <= (wordCnt == LAST) ? 5'd0 : wordCnt + 5'd1;
    end
  end

  // Strobe qualification, RAM read sequencing and capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      RE        <= 1'b0;
      rdAddr    <= '0;
      tempOut   <= '0;
      tempValid <= 1'b0;
      fmtErr    <= 1'b0;
      qual_cnt  <= '0;
      lat_cnt   <= '0;
    end else begin
      RE        <= 1'b0;
      tempValid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (strob_s) begin
            state    <= S_QUALIFY;
            qual_cnt <= '0;
          end
        end
        S_QUALIFY: begin
          if (!strob_s) begin
            state <= S_IDLE;
          end else if (qual_cnt == QMAX) begin
            if (wordCnt == LAST && frameAddr == TEMP_ADDR) begin
              state  <= S_READ;
              RE     <= 1'b1;
              rdAddr <= TEMP_ADDR;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            qual_cnt <= qual_cnt + 2'd1;
          end
        end
        S_READ: begin
          lat_cnt <= '0;
          state   <= (RD_LAT == 1) ? S_CAPTURE : S_LAT;
        end
        S_LAT: begin
          if (lat_cnt == LMAX)
            state <= S_CAPTURE;
          else
            lat_cnt <= lat_cnt + 3'd1;
        end
        S_CAPTURE: begin
          tempOut   <= rdData[10:1];
          tempValid <= 1'b1;
          fmtErr    <= fmtErr | rdData[11] | rdData[0];
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (!strob_s) begin
            state  <= S_IDLE;
            rdAddr <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_orb_temp_reader.sv
// tb_orb_temp_reader: directed scoreboard bench for orb_temp_reader.
// Stimulus pushes expected captures; a monitor pops them on tempValid.
module tb_orb_temp_reader;

  localparam logic [10:0] TA = 11'd831;

  logic        clk = 1'b0;
  logic        rst;
  logic        strob;
  logic        SW;
  logic [10:0] frameAddr;
  logic [11:0] rdData;
  logic        RE;
  logic [10:0] rdAddr;
  logic [9:0]  tempOut;
  logic        tempValid;
  logic        fmtErr;
  logic [4:0]  wordCnt;

  orb_temp_reader #(
    .TEMP_ADDR(TA),
    .RD_LAT(2),
    .QUAL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .strob(strob),
    .SW(SW),
    .frameAddr(frameAddr),
    .rdData(rdData),
    .RE(RE),
    .rdAddr(rdAddr),
    .tempOut(tempOut),
    .tempValid(tempValid),
    .fmtErr(fmtErr),
    .wordCnt(wordCnt)
  );

  always #5 clk = ~clk;

  // RAM model: data valid exactly two cycles after RE, garbage otherwise
  logic [1:0]  pipe;
  logic [11:0] mem_word;
  always @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[0], RE};
  end
  assign rdData = pipe[1] ? mem_word : 12'hFFF;

  typedef struct {
    logic [9:0] t;
    logic       f;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   vecs = 0;
  int   errs = 0;
  int   exp_wc = 0;
  int   exp_re = 0;
  int   re_seen = 0;
  logic re_q = 1'b0;
  logic [9:0] nt;
  logic       nf;

  task automatic chk(input string n, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Monitor: compare every capture and read strobe against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (tempValid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_tempValid", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("tempOut", int'(tempOut), int'(e.t));
          chk("fmtErr_cap", int'(fmtErr), int'(e.f));
        end
      end
      if (RE) begin
        re_seen++;
        chk("rdAddr", int'(rdAddr), int'(TA));
        chk("RE_width", int'(re_q), 0);
      end
      re_q = RE;
    end
  end

  task automatic strobe(input int hi, input logic [10:0] a, input bit q);
    @(negedge clk);
    frameAddr = a;
    strob = 1'b1;
    if (q) begin
      if (exp_wc == 17 && a == TA) begin
        sbq.push_back('{nt, nf});
        exp_re++;
      end
      exp_wc = (exp_wc == 17) ? 0 : exp_wc + 1;
    end
    repeat (hi) @(negedge clk);
    strob = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) strobe(8, 11'(800 + i), 1'b1);
  endtask

  task automatic group(input logic [10:0] last);
    strobes(17);
    strobe(8, last, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_RE"}, int'(RE), 0);
    chk({n, "_rdAddr"}, int'(rdAddr), 0);
    chk({n, "_tempOut"}, int'(tempOut), 0);
    chk({n, "_tempValid"}, int'(tempValid), 0);
    chk({n, "_fmtErr"}, int'(fmtErr), 0);
    chk({n, "_wordCnt"}, int'(wordCnt), 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    strob = 1'b0;
    SW = 1'b0;
    frameAddr = '0;
    mem_word = '0;
    nt = '0;
    nf = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full group, temperature word on the 18th strobe
    mem_word = 12'h2A6; nt = 10'h153; nf = 1'b0;
    group(TA);
    chk("g1_wordCnt", int'(wordCnt), 0);
    chk("g1_tempOut", int'(tempOut), 10'h153);
    chk("g1_fmtErr", int'(fmtErr), 0);

    // Wrong frame address on the 18th strobe: no read
    group(11'd830);
    chk("g2_wordCnt", int'(wordCnt), 0);
    chk("g2_tempOut_hold", int'(tempOut), 10'h153);

    // Short glitches never qualify
    strobe(2, TA, 1'b0);
    chk("glitch0_wordCnt", int'(wordCnt), 0);
    strobes(5);
    strobe(2, TA, 1'b0);
    chk("glitch5_wordCnt", int'(wordCnt), 5);

    // Bad framing bits set the sticky error
    strobes(12);
    chk("pre_err_wordCnt", int'(wordCnt), 17);
    mem_word = 12'h801; nt = 10'h000; nf = 1'b1;
    strobe(8, TA, 1'b1);
    repeat (4) @(negedge clk);
    chk("err_tempOut", int'(tempOut), 0);
    chk("err_fmtErr", int'(fmtErr), 1);
    chk("err_wordCnt", int'(wordCnt), 0);
    mem_word = 12'h2A6; nt = 10'h153; nf = 1'b1;
    group(TA);
    chk("sticky_fmtErr", int'(fmtErr), 1);

    // Group switch restarts the word count
    strobes(10);
    chk("presw_wordCnt", int'(wordCnt), 10);
    @(negedge clk);
    SW = ~SW;
    exp_wc = 0;
    repeat (6) @(negedge clk);
    chk("sw_wordCnt", int'(wordCnt), 0);
    for (int i = 0; i < 17; i++) strobe(8, TA, 1'b1);
    chk("sw17_wordCnt", int'(wordCnt), 17);
    chk("sw17_re_count", re_seen, exp_re);
    strobe(8, TA, 1'b1);
    repeat (4) @(negedge clk);
    chk("sw18_wordCnt", int'(wordCnt), 0);

    // Reset in the middle of a read aborts it
    strobes(17);
    @(negedge clk);
    frameAddr = TA;
    strob = 1'b1;
    exp_re++;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = RE;
    end
    chk("rst_re_seen", int'(seen), 1);
    @(negedge clk);
    rst = 1'b1;
    strob = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    exp_wc = 0;
    nf = 1'b0;
    repeat (4) @(negedge clk);

    // Normal operation after a fresh group
    mem_word = 12'h2A6; nt = 10'h153; nf = 1'b0;
    group(TA);
    chk("post_tempOut", int'(tempOut), 10'h153);
    chk("post_fmtErr", int'(fmtErr), 0);
    chk("post_wordCnt", int'(wordCnt), 0);

    repeat (10) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("re_count", re_seen, exp_re);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
